// File: rtl/isfet_pkg.sv
// rtl/isfet_pkg.sv - shared widths, types and states for the ISFET pixel path
package isfet_pkg;

  localparam int PIX_W        = 10;
  localparam int WORD_W       = 256;
  localparam int PIX_PER_WORD = WORD_W / PIX_W;
  localparam int CNT_W        = 14;
  localparam int NUM_W        = 5;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} piso_state_e;

  // Out-of-range counts (0 or above a full word) mean a full word.
  function automatic logic [NUM_W-1:0] fix_num(input logic [NUM_W-1:0] num);
    if (num == '0 || num > NUM_W'(PIX_PER_WORD)) return NUM_W'(PIX_PER_WORD);
    return num;
  endfunction

endpackage

// File: rtl/piso_256bit.sv
// rtl/piso_256bit.sv - double-buffered 256-bit word to 10-bit pixel unpacker
module piso_256bit
  import isfet_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             PISO_vld,
  input  word_t            PISO_in,
  input  logic [NUM_W-1:0] PISO_num,
  output logic             PISO_rdy,
  input  logic             PISO_en,
  output pixel_t           PISO_out,
  output logic             PISO_out_vld,
  output logic             PISO_last,
  output logic [CNT_W-1:0] PISO_pix_cnt,
  output logic             PISO_frame_end
);

  piso_state_e      state;
  word_t            shift_q;
  word_t            hold_q;
  logic [NUM_W-1:0] shift_rem;
  logic [NUM_W-1:0] hold_rem;

  logic accept;
  logic consume;
  logic last_consume;

  assign accept       = PISO_vld && PISO_rdy;
  assign consume      = PISO_out_vld && PISO_en;
  assign last_consume = consume && (shift_rem == NUM_W'(1));

  assign PISO_out  = shift_q[PIX_W-1:0];
  assign PISO_last = (shift_rem == NUM_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= EMPTY;
      shift_q        <= '0;
      hold_q         <= '0;
      shift_rem      <= '0;
      hold_rem       <= '0;
      PISO_rdy       <= 1'b0;
      PISO_out_vld   <= 1'b0;
      PISO_pix_cnt   <= '0;
      PISO_frame_end <= 1'b0;
    end else begin
      PISO_frame_end <= consume && (PISO_pix_cnt == '1);
      if (consume) PISO_pix_cnt <= PISO_pix_cnt + 1'b1;

      case (state)
        EMPTY: begin
          PISO_rdy <= 1'b1;
          if (accept) begin
            shift_q      <= PISO_in;
            shift_rem    <= fix_num(PISO_num);
            PISO_out_vld <= 1'b1;
            state        <= ONE;
          end
        end

        ONE: begin
          if (last_consume) begin
            // A word arriving as the last pixel leaves goes straight to the shifter.
            if (accept) begin
              shift_q   <= PISO_in;
              shift_rem <= fix_num(PISO_num);
            end else begin
              shift_rem    <= '0;
              PISO_out_vld <= 1'b0;
              state        <= EMPTY;
            end
          end else begin
            if (consume) begin
              shift_q   <= shift_q >> PIX_W;
              shift_rem <= shift_rem - NUM_W'(1);
            end
            if (accept) begin
              hold_q   <= PISO_in;
              hold_rem <= fix_num(PISO_num);
              PISO_rdy <= 1'b0;
              state    <= TWO;
            end
          end
        end

        TWO: begin
          if (last_consume) begin
            shift_q   <= hold_q;
            shift_rem <= hold_rem;
            hold_rem  <= '0;
            PISO_rdy  <= 1'b1;
            state     <= ONE;
          end else if (consume) begin
            shift_q   <= shift_q >> PIX_W;
            shift_rem <= shift_rem - NUM_W'(1);
          end
        end

        default: state <= EMPTY;
      endcase
    end
  end

endmodule
